collision_resolver: RTL and testbench

COLLISION_RESOLVER -- requirements
Module: collision_resolver

---
 rtl/collision_resolver.sv | 130 +++++++++++++
 tb/tb_collision_resolver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/collision_resolver.sv
// rtl/collision_resolver.sv - per-frame player/obstacle collision resolution FSM
// Latches one frame on start, then either free-moves the player or pushes it out of the obstacle.
module collision_resolver (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] pos_in,
  input  logic [31:0] vel_in,
  input  logic [31:0] size_in,
  input  logic [31:0] obj_pos,
  input  logic [31:0] obj_size,
  input  logic [3:0]  coll,
  output logic        busy,
  output logic        done,
  output logic [31:0] pos_out,
  output logic [31:0] vel_out,
  output logic        grounded,
  output logic [7:0]  hit_count
);

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, DONE} state_t;

  state_t      state;
  logic [31:0] p, v, sz, op, os;
  logic [3:0]  c;
  logic        grnd;

  logic [15:0] x, y, vx, vy, w, h, ox, oy, ow, oh;
  logic [31:0] mov_pos, res_pos, res_vel;
  logic        res_grnd;

  assign x  = p[31:16];
  assign y  = p[15:0];
  assign vx = v[31:16];
  assign vy = v[15:0];
  assign w  = sz[31:16];
  assign h  = sz[15:0];
  assign ox = op[31:16];
  assign oy = op[15:0];
  assign ow = os[31:16];
  assign oh = os[15:0];

  // Components are added separately so no carry crosses from y into x.
  assign mov_pos = {x + vx, y + vy};

  // Vertical motion takes priority; a purely horizontal overlap is a wall hit.
  always_comb begin
    res_pos  = p;
    res_vel  = v;
    res_grnd = 1'b0;
    if (vy != 16'd0) begin
      res_pos[31:16] = x + vx;
      res_vel[15:0]  = 16'd0;
      if (!vy[15]) begin
        res_pos[15:0] = oy - h - 16'd1;
        res_grnd      = 1'b1;
      end else begin
        res_pos[15:0] = oy + oh + 16'd1;
      end
    end else if (vx != 16'd0) begin
      res_vel[31:16] = 16'd0;
      if (!vx[15]) res_pos[31:16] = ox - w - 16'd1;
      else         res_pos[31:16] = ox + ow + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pos_out   <= 32'd0;
      vel_out   <= 32'd0;
      grounded  <= 1'b0;
      hit_count <= 8'd0;
      p         <= 32'd0;
      v         <= 32'd0;
      sz        <= 32'd0;
      op        <= 32'd0;
      os        <= 32'd0;
      c         <= 4'd0;
      grnd      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p     <= pos_in;
            v     <= vel_in;
            sz    <= size_in;
            op    <= obj_pos;
            os    <= obj_size;
            c     <= coll;
            busy  <= 1'b1;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (c == 4'b1111) begin
            state <= RESOLVE;
          end else begin
            p     <= mov_pos;
            grnd  <= 1'b0;
            state <= DONE;
          end
        end
        RESOLVE: begin
          p    <= res_pos;
          v    <= res_vel;
          grnd <= res_grnd;
          if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          state <= DONE;
        end
        DONE: begin
          pos_out  <= p;
          vel_out  <= v;
          grounded <= grnd;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_resolver.sv
// tb/tb_collision_resolver.sv - scoreboard bench for collision_resolver
module tb_collision_resolver;

  logic        clock = 1'b0;
  logic        resetn, start;
  logic [31:0] pos_in, vel_in, size_in, obj_pos, obj_size;
  logic [3:0]  coll;
  logic        busy, done, grounded;
  logic [31:0] pos_out, vel_out;
  logic [7:0]  hit_count;

  collision_resolver dut (
    .clock(clock), .resetn(resetn), .start(start),
    .pos_in(pos_in), .vel_in(vel_in), .size_in(size_in),
    .obj_pos(obj_pos), .obj_size(obj_size), .coll(coll),
    .busy(busy), .done(done), .pos_out(pos_out), .vel_out(vel_out),
    .grounded(grounded), .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pos;
    logic [31:0] vel;
    logic        gr;
    logic [7:0]  hits;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_hits = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_pos"},  pos_out, e.pos);
        check({e.name, "_vel"},  vel_out, e.vel);
        check({e.name, "_gr"},   {31'd0, grounded}, {31'd0, e.gr});
        check({e.name, "_hits"}, {24'd0, hit_count}, {24'd0, e.hits});
        check({e.name, "_lat"},  cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge; drives one start cycle then scrambles the inputs.
  task automatic fire(input string name, input logic [31:0] p, input logic [31:0] v,
                      input logic [31:0] s, input logic [31:0] op, input logic [31:0] os,
                      input logic [3:0] c, input logic [31:0] ep, input logic [31:0] ev,
                      input logic eg, input bit expect_done);
    exp_t e;
    pos_in = p; vel_in = v; size_in = s; obj_pos = op; obj_size = os; coll = c;
    start = 1'b1;
    if (c == 4'b1111 && exp_hits < 255) exp_hits++;
    e.pos = ep; e.vel = ev; e.gr = eg; e.hits = 8'(exp_hits); e.name = name;
    e.cyc = cyc + ((c == 4'b1111) ? 4 : 3);
    if (expect_done) q.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    pos_in = $urandom; vel_in = $urandom; size_in = $urandom;
    obj_pos = $urandom; obj_size = $urandom; coll = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got %0d outstanding frames expected 0", q.size());
      q.delete();
    end
    @(posedge clock); #1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; coll = 4'd0;
    pos_in = '0; vel_in = '0; size_in = '0; obj_pos = '0; obj_size = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pos", pos_out, 32'd0);
    check("rst_vel", vel_out, 32'd0);
    check("rst_gr", {31'd0, grounded}, 32'd0);
    check("rst_hits", {24'd0, hit_count}, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    fire("free", 32'h006400C8, 32'h0003FFFE, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b1011, 32'h006700C6, 32'h0003FFFE, 1'b0, 1'b1);
    wait_idle();
    fire("land", 32'h006400BE, 32'h00000005, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b1111, 32'h006400B3, 32'h00000000, 1'b1, 1'b1);
    wait_idle();
    fire("ceil", 32'h00640068, 32'h0000FFFD, 32'h00100014, 32'h00320064, 32'h00C8000A,
         4'b1111, 32'h0064006F, 32'h00000000, 1'b0, 1'b1);
    wait_idle();
    fire("wall_r", 32'h005F00C8, 32'h00040000, 32'h00100014, 32'h006E0096, 32'h00C8000A,
         4'b1111, 32'h005D00C8, 32'h00000000, 1'b0, 1'b1);
    wait_idle();
    // Moving left into the obstacle: x = 0x006E + 0x0020 + 1 = 0x008F.
    fire("wall_l", 32'h008000C8, 32'hFFFE0000, 32'h00100014, 32'h006E0096, 32'h0020000A,
         4'b1111, 32'h008F00C8, 32'h00000000, 1'b0, 1'b1);
    wait_idle();
    // Landing while drifting right: x follows vx, y snaps above obstacle (0x00C8-0x14-1).
    fire("land_dx", 32'h006400BE, 32'h00020003, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b1111, 32'h006600B3, 32'h00020000, 1'b1, 1'b1);
    wait_idle();
    fire("wrap", 32'hFFFE0010, 32'h00030000, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b0000, 32'h00010010, 32'h00030000, 1'b0, 1'b1);
    wait_idle();
    // y wrap must not borrow from x.
    fire("wrap_y", 32'h00050001, 32'h0000FFFD, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b0111, 32'h0005FFFE, 32'h0000FFFD, 1'b0, 1'b1);
    wait_idle();

    fire("busy", 32'h00100010, 32'h00010001, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b0001, 32'h00110011, 32'h00010001, 1'b0, 1'b1);
    check("busy_eval", {31'd0, busy}, 32'd1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();
    repeat (6) @(posedge clock);
    #1;

    for (int i = 0; i < 256; i++) begin
      fire("sat", 32'h12345678, 32'h00000000, 32'h00100014, 32'h003200C8, 32'h00C8000A,
           4'b1111, 32'h12345678, 32'h00000000, 1'b0, 1'b1);
      wait_idle();
    end
    check("sat_final", {24'd0, hit_count}, 32'd255);

    fire("abort", 32'h006400BE, 32'h00000005, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b1111, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_pos", pos_out, 32'd0);
    check("abort_vel", vel_out, 32'd0);
    check("abort_gr", {31'd0, grounded}, 32'd0);
    check("abort_hits", {24'd0, hit_count}, 32'd0);
    exp_hits = 0;
    resetn = 1'b1;
    fire("post_rst", 32'h006400BE, 32'h00000005, 32'h00100014, 32'h003200C8, 32'h00C8000A,
         4'b1111, 32'h006400B3, 32'h00000000, 1'b1, 1'b1);
    wait_idle();
    repeat (4) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
